// File: rtl/control_multiciclo.sv
`default_nettype none
// ============================================================================
// Module  : control_multiciclo
// Brief   : Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for
//           the R-type/lw/sw datapath, with registered one-hot write strobes.
// Rev     : 1.0  initial release
// ============================================================================
module control_multiciclo #(
    parameter int PC_WIDTH  = 32,
    parameter int PC_STEP   = 4,
    parameter int RESET_PC  = 0,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_data,
    output logic [31:0]          instruccion,
    output logic                 reg_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic [2:0]           alu_op,
    output logic                 busy,
    output logic                 halted,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] instr_count
);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_FETCH     = 3'd1;
    localparam logic [2:0] c_S_DECODE    = 3'd2;
    localparam logic [2:0] c_S_EXECUTE   = 3'd3;
    localparam logic [2:0] c_S_MEMORY    = 3'd4;
    localparam logic [2:0] c_S_WRITEBACK = 3'd5;
    localparam logic [2:0] c_S_HALT      = 3'd6;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_HALT  = 6'b111111;

    localparam logic [PC_WIDTH-1:0]  c_RESET_PC = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0]  c_PC_STEP  = PC_WIDTH'(PC_STEP);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [PC_WIDTH-1:0]  r_pc;
    logic [31:0]          r_instr;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_imem_req;
    logic                 r_reg_write;
    logic                 r_mem_read;
    logic                 r_mem_write;
    logic                 r_mem_to_reg;
    logic                 r_illegal;

    logic [5:0] w_opcode;
    logic       w_is_rtype;
    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_halt;
    logic       w_is_illegal;
    logic       w_retire;

    assign w_opcode     = r_instr[31:26];
    assign w_is_rtype   = (w_opcode == c_OP_RTYPE);
    assign w_is_lw      = (w_opcode == c_OP_LW);
    assign w_is_sw      = (w_opcode == c_OP_SW);
    assign w_is_halt    = (w_opcode == c_OP_HALT);
    assign w_is_illegal = !(w_is_rtype || w_is_lw || w_is_sw || w_is_halt);

    // sw retires out of MEMORY; R-type and lw retire out of WRITEBACK
    assign w_retire = (r_state == c_S_WRITEBACK) ||
                      ((r_state == c_S_MEMORY) && w_is_sw);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:      if (start) w_state_nxt = c_S_FETCH;
            c_S_FETCH:     if (imem_ack) w_state_nxt = c_S_DECODE;
            c_S_DECODE: begin
                if (w_is_halt)         w_state_nxt = c_S_HALT;
                else if (w_is_illegal) w_state_nxt = c_S_FETCH;
                else                   w_state_nxt = c_S_EXECUTE;
            end
            c_S_EXECUTE:   w_state_nxt = w_is_rtype ? c_S_WRITEBACK : c_S_MEMORY;
            c_S_MEMORY:    w_state_nxt = w_is_lw ? c_S_WRITEBACK : c_S_FETCH;
            c_S_WRITEBACK: w_state_nxt = c_S_FETCH;
            c_S_HALT:      w_state_nxt = c_S_HALT;
            default:       w_state_nxt = c_S_IDLE;
        endcase
    end

    // Strobes are computed from the next state so each one is a clean flop
    // output that is high for exactly the cycle spent in its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_pc         <= c_RESET_PC;
            r_instr      <= '0;
            r_count      <= '0;
            r_imem_req   <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_imem_req   <= (w_state_nxt == c_S_FETCH);
            r_reg_write  <= (w_state_nxt == c_S_WRITEBACK);
            r_mem_to_reg <= (w_state_nxt == c_S_WRITEBACK) && w_is_lw;
            r_mem_read   <= (w_state_nxt == c_S_MEMORY) && w_is_lw;
            r_mem_write  <= (w_state_nxt == c_S_MEMORY) && w_is_sw;
            if ((r_state == c_S_FETCH) && imem_ack) begin
                r_instr <= imem_data;
                r_pc    <= r_pc + c_PC_STEP;
            end
            if ((r_state == c_S_DECODE) && w_is_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_count <= r_count + c_CNT_ONE;
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instruccion = r_instr;
    assign reg_write   = r_reg_write;
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_to_reg  = r_mem_to_reg;
    assign alu_op      = w_is_rtype ? 3'b010 : 3'b000;
    assign busy        = (r_state != c_S_IDLE) && (r_state != c_S_HALT);
    assign halted      = (r_state == c_S_HALT);
    assign illegal_op  = r_illegal;
    assign instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_control_multiciclo.sv
`default_nettype none
// ============================================================================
// Module  : tb_control_multiciclo
// Brief   : Directed bench for control_multiciclo with a per-instruction
//           step-schedule model checked every cycle.
// Rev     : 1.0  initial release
// ============================================================================
module tb_control_multiciclo;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instruccion;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic [2:0]  alu_op;
    logic        busy;
    logic        halted;
    logic        illegal_op;
    logic [15:0] instr_count;

    control_multiciclo #(
        .PC_WIDTH (32),
        .PC_STEP  (4),
        .RESET_PC (0),
        .CNT_WIDTH(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_data  (imem_data),
        .instruccion(instruccion),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .busy       (busy),
        .halted     (halted),
        .illegal_op (illegal_op),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] c_RTYPE = 32'h012A4020;
    localparam logic [31:0] c_LW    = 32'h8D090004;
    localparam logic [31:0] c_SW    = 32'hAD090004;
    localparam logic [31:0] c_ILL   = 32'h08000000;
    localparam logic [31:0] c_HALT  = 32'hFC000000;

    logic [31:0] prog [16];
    assign imem_data = prog[imem_addr[5:2]];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory responder: ack after wait_n request cycles, or always.
    logic tie_ack = 1'b0;
    int   wait_n  = 0;
    int   wcnt    = 0;
    initial begin
        imem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (tie_ack) begin
                imem_ack = 1'b1;
            end else if (imem_req) begin
                imem_ack = (wcnt == wait_n);
                wcnt++;
            end else begin
                imem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Model: after each fetch, the opcode expands into a list of per-cycle steps.
    typedef struct packed {
        logic rw, mr, mw, mtr, ret, ill, hlt;
    } step_t;

    function automatic step_t mk(input logic rw, mr, mw, mtr, ret, ill, hlt);
        step_t s;
        s.rw = rw; s.mr = mr; s.mw = mw; s.mtr = mtr;
        s.ret = ret; s.ill = ill; s.hlt = hlt;
        return s;
    endfunction

    bit          m_run, m_halt, m_fetch, m_ill;
    logic [31:0] m_pc, m_ir;
    logic [15:0] m_cnt;
    step_t       m_q[$];

    task automatic m_reset();
        m_run = 0; m_halt = 0; m_fetch = 0; m_ill = 0;
        m_pc = 0; m_ir = 0; m_cnt = 0;
        m_q.delete();
    endtask

    task automatic m_plan(input logic [5:0] op);
        m_q.delete();
        case (op)
            6'b000000: begin
                m_q.push_back(mk(0,0,0,0,0,0,0));
                m_q.push_back(mk(0,0,0,0,0,0,0));
                m_q.push_back(mk(1,0,0,0,1,0,0));
            end
            6'b100011: begin
                m_q.push_back(mk(0,0,0,0,0,0,0));
                m_q.push_back(mk(0,0,0,0,0,0,0));
                m_q.push_back(mk(0,1,0,0,0,0,0));
                m_q.push_back(mk(1,0,0,1,1,0,0));
            end
            6'b101011: begin
                m_q.push_back(mk(0,0,0,0,0,0,0));
                m_q.push_back(mk(0,0,0,0,0,0,0));
                m_q.push_back(mk(0,0,1,0,1,0,0));
            end
            6'b111111: m_q.push_back(mk(0,0,0,0,0,0,1));
            default:   m_q.push_back(mk(0,0,0,0,0,1,0));
        endcase
    endtask

    initial begin
        step_t s;
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_reset();
            end else if (!m_run) begin
                if (start) begin
                    m_run = 1; m_fetch = 1;
                end
            end else if (m_halt) begin
                m_halt = 1;
            end else if (m_fetch) begin
                if (imem_ack) begin
                    m_ir = imem_data;
                    m_pc = m_pc + 32'd4;
                    m_fetch = 0;
                    m_plan(imem_data[31:26]);
                end
            end else if (m_q.size() > 0) begin
                s = m_q.pop_front();
                if (s.ret) m_cnt = m_cnt + 16'd1;
                if (s.ill) m_ill = 1;
                if (s.hlt) m_halt = 1;
                else if (m_q.size() == 0) m_fetch = 1;
            end
        end
    end

    initial begin
        step_t e;
        forever begin
            @(negedge clk);
            e = '0;
            if (m_run && !m_halt && !m_fetch && m_q.size() > 0) e = m_q[0];
            check("imem_req",    imem_req,    m_run && !m_halt && m_fetch);
            check("imem_addr",   imem_addr,   m_pc);
            check("instruccion", instruccion, m_ir);
            check("reg_write",   reg_write,   e.rw);
            check("mem_read",    mem_read,    e.mr);
            check("mem_write",   mem_write,   e.mw);
            check("mem_to_reg",  mem_to_reg,  e.mtr);
            check("alu_op",      alu_op,      (m_ir[31:26] == 6'd0) ? 3'b010 : 3'b000);
            check("busy",        busy,        m_run && !m_halt);
            check("halted",      halted,      m_halt);
            check("illegal_op",  illegal_op,  m_ill);
            check("instr_count", instr_count, m_cnt);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #3;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic wait_halted(input int max);
        int k = 0;
        while (!halted && k < max) begin
            next_cycle();
            k++;
        end
        check("halt_reached", halted, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 16; i++) prog[i] = c_HALT;

        // R-type with ack tied high
        tie_ack = 1'b1;
        prog[0] = c_RTYPE;
        prog[1] = c_HALT;
        do_reset();
        check("rst_req",   imem_req,    1'b0);
        check("rst_busy",  busy,        1'b0);
        check("rst_count", instr_count, 16'd0);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        check("r_c1_req",  imem_req,  1'b1);
        check("r_c1_addr", imem_addr, 32'd0);
        next_cycle();
        check("r_c2_addr", imem_addr,   32'd4);
        check("r_c2_ir",   instruccion, c_RTYPE);
        check("r_c2_alu",  alu_op,      3'b010);
        next_cycle();
        check("r_c3_rw",   reg_write,   1'b0);
        next_cycle();
        check("r_c4_rw",   reg_write,   1'b1);
        check("r_c4_mtr",  mem_to_reg,  1'b0);
        next_cycle();
        check("r_c5_rw",   reg_write,   1'b0);
        check("r_c5_cnt",  instr_count, 16'd1);
        wait_halted(20);

        // lw, zero-wait ack
        tie_ack = 1'b0;
        wait_n = 0;
        prog[0] = c_LW;
        do_reset();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (3) next_cycle();
        check("lw_c4_mr",  mem_read,   1'b1);
        check("lw_c4_rw",  reg_write,  1'b0);
        next_cycle();
        check("lw_c5_rw",  reg_write,  1'b1);
        check("lw_c5_mtr", mem_to_reg, 1'b1);
        check("lw_c5_mr",  mem_read,   1'b0);
        wait_halted(20);

        // sw
        prog[0] = c_SW;
        do_reset();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (3) next_cycle();
        check("sw_c4_mw",   mem_write, 1'b1);
        check("sw_c4_rw",   reg_write, 1'b0);
        next_cycle();
        check("sw_c5_mw",   mem_write, 1'b0);
        check("sw_c5_req",  imem_req,  1'b1);
        check("sw_c5_addr", imem_addr, 32'd4);
        check("sw_c5_cnt",  instr_count, 16'd1);
        wait_halted(20);

        // R-type with three ack wait-states
        wait_n = 3;
        prog[0] = c_RTYPE;
        do_reset();
        start = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            start = 1'b0;
            check("wait_req",  imem_req,    1'b1);
            check("wait_addr", imem_addr,   32'd0);
            check("wait_ir",   instruccion, 32'd0);
        end
        next_cycle();
        check("wait_c5_ir", instruccion, c_RTYPE);
        next_cycle();
        check("wait_c6_rw", reg_write, 1'b0);
        next_cycle();
        check("wait_c7_rw", reg_write, 1'b1);
        next_cycle();
        check("wait_c8_addr", imem_addr, 32'd4);
        check("wait_c8_cnt",  instr_count, 16'd1);
        wait_halted(40);

        // illegal then halt; start ignored in HALT
        wait_n = 0;
        prog[0] = c_ILL;
        prog[1] = c_HALT;
        do_reset();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (2) next_cycle();
        check("ill_c3_flag", illegal_op, 1'b1);
        check("ill_c3_addr", imem_addr,  32'd4);
        repeat (2) next_cycle();
        check("ill_c5_halted", halted,      1'b1);
        check("ill_c5_busy",   busy,        1'b0);
        check("ill_c5_cnt",    instr_count, 16'd0);
        start = 1'b1;
        repeat (10) next_cycle();
        start = 1'b0;
        check("ill_stay_halted", halted,     1'b1);
        check("ill_stay_req",    imem_req,   1'b0);
        check("ill_sticky",      illegal_op, 1'b1);

        // reset in MEMORY of a sw
        prog[0] = c_SW;
        do_reset();
        check("rst_ill_clear", illegal_op, 1'b0);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (3) next_cycle();
        check("mid_mw_before", mem_write, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_mw",   mem_write,   1'b0);
        check("mid_busy", busy,        1'b0);
        check("mid_pc",   imem_addr,   32'd0);
        check("mid_cnt",  instr_count, 16'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        check("mid_resume_req",  imem_req,  1'b1);
        check("mid_resume_addr", imem_addr, 32'd0);
        wait_halted(20);
        check("mid_final_cnt", instr_count, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
Multi-cycle sequencer for the R-type/load/store datapath. Fetches 32-bit instructions from an instruction memory through a req/ack handshake, holds each one in an instruction register, and steps it through DECODE/EXECUTE/MEMORY/WRITEBACK. In each state it drives the datapath's write enables (register bank, data memory, writeback mux select) so that every write lands in exactly one cycle. It sits above the datapath and replaces the free-running, purely combinational opcode decode.

Parameters:
PC_WIDTH, 32, program counter and instruction address width
PC_STEP, 4, PC increment per fetched instruction
RESET_PC, 0, PC value after reset
CNT_WIDTH, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  begin execution from IDLE (level or pulse, sampled in IDLE only)
imem_req  out  1  instruction fetch request
imem_addr  out  PC_WIDTH  fetch address (= pc)
imem_ack  in  1  fetch complete; imem_data valid this cycle
imem_data  in  32  fetched instruction
instruccion  out  32  instruction register contents, to datapath field decode
reg_write  out  1  register bank write enable
mem_read  out  1  data memory read strobe
mem_write  out  1  data memory write strobe
mem_to_reg  out  1  writeback select: 1 = memory data, 0 = ALU result
alu_op  out  3  ALU control class: 010 R-type, 000 lw/sw, 000 otherwise
busy  out  1  high in every state except IDLE and HALT
halted  out  1  high in HALT
illegal_op  out  1  sticky: an unsupported opcode was decoded
instr_count  out  CNT_WIDTH  retired instructions, wraps modulo 2^CNT_WIDTH

Behaviour:
- Opcodes (instruccion[31:26]): 000000 R-type, 100011 lw, 101011 sw, 111111 halt. Any other opcode is illegal.
- Reset (async, immediate): state IDLE; pc=RESET_PC; instruccion=0; instr_count=0.
- Reset clears all outputs: imem_req, reg_write, mem_read, mem_write, mem_to_reg, busy, halted, illegal_op all 0.
- Reset mid-fetch drops imem_req in the same instant; an ack arriving during reset is ignored.
- IDLE: if start=1, go to FETCH next cycle.
- FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - On the ack edge: instruccion<=imem_data; pc<=pc+PC_STEP (wraps modulo 2^PC_WIDTH); go to DECODE.
  - imem_req deasserts in the cycle after the ack.
  - imem_ack outside FETCH is ignored.
- DECODE (1 cycle), next state by opcode:
  - halt: go to HALT; instr_count unchanged.
  - illegal: set illegal_op; go to FETCH; the instruction is not retired.
  - otherwise: go to EXECUTE.
- EXECUTE (1 cycle): no strobes. R-type goes to WRITEBACK; lw and sw go to MEMORY.
- MEMORY (1 cycle):
  - lw: mem_read=1; go to WRITEBACK.
  - sw: mem_write=1; retire; go to FETCH.
- WRITEBACK (1 cycle): reg_write=1; mem_to_reg=1 for lw, 0 for R-type; retire; go to FETCH.
- Retire: instr_count increments on the edge that leaves the retiring state.
- Strobe rules:
  - reg_write, mem_read and mem_write are registered and one-hot; each is high for exactly one cycle per instruction.
  - mem_to_reg is 0 outside WRITEBACK.
- alu_op is decoded from instruccion and is stable from DECODE through WRITEBACK.
- HALT: halted=1, busy=0. The block stays in HALT, ignoring start, until rst.
- Latency with an ack in the first FETCH cycle:
  - R-type: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - Each extra ack wait-state adds 1 cycle.
- illegal_op is cleared only by rst.

Test Plan:
- Reset then start=1, imem_ack tied high, program {R-type 0x012A4020} → imem_addr 0 then 4; reg_write high exactly in cycle 4 after the first FETCH; mem_to_reg=0; alu_op=010; instr_count=1.
- lw 0x8D090004 with zero-wait ack → mem_read high in cycle 4, then reg_write with mem_to_reg=1 in cycle 5; mem_write never high.
- sw 0xAD090004 → mem_write high for one cycle in MEMORY; reg_write stays 0; next fetch address = previous +4.
- Ack delayed 3 cycles during FETCH → imem_req and imem_addr held stable for all 3 cycles; instruccion unchanged until the ack edge; R-type total is 7 cycles.
- Illegal opcode 0x08000000 followed by halt 0xFC000000 → illegal_op=1, no strobes for the illegal instruction, halted=1, busy=0, instr_count=0; start ignored afterwards.
- rst asserted in MEMORY of a sw → mem_write and busy drop immediately; pc=0, instr_count=0; after release with start=1, fetch resumes at address 0.
